// File: rtl/reflex_target_gen_pkg.sv
// Shared game definitions for the reflex target generator and the score counter.
package reflex_target_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } game_state_t;

  // Timer value that ends a game; the score counter clears on the same value.
  localparam int GAME_TIMER_END = 31;

  localparam logic [15:0] LFSR_MASK      = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF  = 16'hACE1;

  // Registered one-cycle result of a SHOW cycle.
  typedef struct packed {
    logic hit;
    logic miss;
  } pulse_t;

  // One step of the 16-bit Galois LFSR (right shift, feedback from bit 0).
  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/reflex_target_gen_sw_sync.sv
// Switch conditioning: per-bit 2-flop synchronizer plus an edge register.
// A toggle is reported for exactly one cycle whenever the synchronized level changes.

// Single switch lane.
module reflex_sw_sync_lane (
  input  logic clk_2,
  input  logic rst,
  input  logic swRaw,
  output logic swS,
  output logic tog
);
  logic meta;
  logic swD;

  // Two metastability flops, then the previous-level register.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      swS  <= 1'b0;
      swD  <= 1'b0;
    end else begin
      meta <= swRaw;
      swS  <= meta;
      swD  <= swS;
    end
  end

  assign tog = swS ^ swD;
endmodule

// LED_W lanes side by side.
module reflex_sw_sync #(
  parameter int LED_W = 16
) (
  input  logic             clk_2,
  input  logic             rst,
  input  logic [LED_W-1:0] sw,
  output logic [LED_W-1:0] swS,
  output logic [LED_W-1:0] toggles
);
  for (genvar i = 0; i < LED_W; i++) begin : gLane
    reflex_sw_sync_lane uLane (
      .clk_2 (clk_2),
      .rst   (rst),
      .swRaw (sw[i]),
      .swS   (swS[i]),
      .tog   (toggles[i])
    );
  end
endmodule

// File: rtl/reflex_target_gen.sv
// Reflex game target generator: lights a pseudo-random LED, scores the player's
// toggle as hit or miss, forces a miss on timeout and stops when the round timer ends.
module reflex_target_gen
  import reflex_target_gen_pkg::*;
#(
  parameter int          LED_W          = 16,
  parameter int          TIMER_W        = 6,
  parameter int          TIMER_END      = reflex_target_gen_pkg::GAME_TIMER_END,
  parameter int          TARGET_TIMEOUT = 8,
  parameter logic [15:0] LFSR_SEED      = reflex_target_gen_pkg::LFSR_SEED_DEF
) (
  input  logic               clk_2,
  input  logic               rst,
  input  logic               start,
  input  logic [TIMER_W-1:0] timer_in,
  input  logic [LED_W-1:0]   sw,
  output logic [LED_W-1:0]   led,
  output logic               hit,
  output logic               miss,
  output logic               game_active
);
  localparam int IDX_W  = $clog2(LED_W);
  localparam int TCNT_W = $clog2(TARGET_TIMEOUT);

  game_state_t      state, stateNext;
  logic [15:0]      lfsr;
  logic [IDX_W-1:0] prevIdx, prevNext, rawIdx, pickIdx;
  logic [TCNT_W-1:0] tcnt, tcntNext;
  logic [LED_W-1:0] ledNext;
  pulse_t           pulse, pulseNext;
  logic [LED_W-1:0] toggles;
  logic [LED_W-1:0] unusedSwS;   // synchronized level; only the toggles matter here
  logic             timerEnd;
  logic             timeoutHit;

  reflex_sw_sync #(.LED_W(LED_W)) uSwSync (
    .clk_2   (clk_2),
    .rst     (rst),
    .sw      (sw),
    .swS     (unusedSwS),
    .toggles (toggles)
  );

  assign timerEnd   = (timer_in == TIMER_W'(TIMER_END));
  assign timeoutHit = (tcnt == TCNT_W'(TARGET_TIMEOUT - 1));

  // Target pick: low LFSR bits, bumped by one when it would repeat the last target.
  always_comb begin
    rawIdx  = lfsr[IDX_W-1:0];
    pickIdx = (rawIdx == prevIdx) ? rawIdx + IDX_W'(1) : rawIdx;
  end

  // Next-state and registered-output decode.
  always_comb begin
    stateNext = state;
    ledNext   = led;
    tcntNext  = tcnt;
    prevNext  = prevIdx;
    pulseNext = '0;
    case (state)
      IDLE: begin
        ledNext = '0;
        if (start) stateNext = LOAD;
      end
      LOAD: begin
        if (timerEnd) begin
          stateNext = IDLE;
          ledNext   = '0;
        end else begin
          ledNext   = LED_W'(1) << pickIdx;
          prevNext  = pickIdx;
          tcntNext  = '0;
          stateNext = SHOW;
        end
      end
      SHOW: begin
        tcntNext = tcnt + TCNT_W'(1);
        if (timerEnd) begin
          stateNext = IDLE;
          ledNext   = '0;
        end else if (toggles == led) begin
          pulseNext.hit = 1'b1;
          stateNext     = LOAD;
          ledNext       = '0;
        end else if (|toggles) begin
          pulseNext.miss = 1'b1;
          stateNext      = LOAD;
          ledNext        = '0;
        end else if (timeoutHit) begin
          pulseNext.miss = 1'b1;
          stateNext      = LOAD;
          ledNext        = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        ledNext   = '0;
      end
    endcase
  end

  // State, outputs and LFSR; the LFSR free-runs and recovers from the all-zero lock-up.
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      led         <= '0;
      pulse       <= '0;
      game_active <= 1'b0;
      lfsr        <= LFSR_SEED;
      prevIdx     <= '0;
      tcnt        <= '0;
    end else begin
      state       <= stateNext;
      led         <= ledNext;
      pulse       <= pulseNext;
      game_active <= (stateNext != IDLE);
      lfsr        <= (lfsr == 16'h0000) ? LFSR_SEED : lfsrStep(lfsr);
      prevIdx     <= prevNext;
      tcnt        <= tcntNext;
    end
  end

  assign hit  = pulse.hit;
  assign miss = pulse.miss;

endmodule

// File: tb/tb_reflex_target_gen.sv
// Directed bench for reflex_target_gen with a per-cycle reference model.
module tb_reflex_target_gen;

  logic        clk_2 = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  timer_in = 6'd0;
  logic [15:0] sw = 16'hFFFF;
  logic [15:0] led;
  logic        hit, miss, game_active;

  int checks   = 0;
  int failures = 0;

  always #5 clk_2 = ~clk_2;

  reflex_target_gen dut (
    .clk_2       (clk_2),
    .rst         (rst),
    .start       (start),
    .timer_in    (timer_in),
    .sw          (sw),
    .led         (led),
    .hit         (hit),
    .miss        (miss),
    .game_active (game_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] nextLfsr(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'h0000) return 16'hACE1;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int choose(input logic [15:0] v, input int prev);
    int i = v % 16;
    if (i == prev) i = (i + 1) % 16;
    return i;
  endfunction

  // phase: 0 idle, 1 load, 2 show. h0..h2: sw samples at the last three edges.
  typedef struct packed {
    logic [1:0]  phase;
    logic [15:0] lfsr;
    logic [3:0]  prev;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic [15:0] led;
    logic        hit;
    logic        miss;
    logic        active;
    logic [15:0] h0;
    logic [15:0] h1;
    logic [15:0] h2;
  } mdl_t;

  function automatic mdl_t mdlReset();
    mdl_t r = '0;
    r.lfsr = 16'hACE1;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic [15:0] swIn,
                                input logic st, input logic [5:0] tmr);
    mdl_t        n    = s;
    logic [15:0] tog  = s.h1 ^ s.h2;
    logic        endT = (tmr == 6'd31);
    n.h0 = swIn; n.h1 = s.h0; n.h2 = s.h1;
    n.hit = 1'b0; n.miss = 1'b0;
    case (s.phase)
      2'd0: if (st) n.phase = 2'd1;
      2'd1: begin
        if (endT) n.phase = 2'd0;
        else begin
          n.idx   = 4'(choose(s.lfsr, int'(s.prev)));
          n.prev  = n.idx;
          n.led   = 16'h0001 << n.idx;
          n.cnt   = 4'd0;
          n.phase = 2'd2;
        end
      end
      default: begin
        if (endT) begin n.phase = 2'd0; n.led = 16'h0; end
        else if (tog == s.led) begin n.hit = 1'b1; n.phase = 2'd1; n.led = 16'h0; end
        else if (tog != 16'h0) begin n.miss = 1'b1; n.phase = 2'd1; n.led = 16'h0; end
        else if (s.cnt == 4'd7) begin n.miss = 1'b1; n.phase = 2'd1; n.led = 16'h0; end
        else n.cnt = s.cnt + 4'd1;
      end
    endcase
    n.active = (n.phase != 2'd0);
    n.lfsr   = nextLfsr(s.lfsr);
    return n;
  endfunction

  mdl_t m;

  // Model advances on the same edges as the DUT.
  always @(posedge clk_2 or posedge rst) begin
    if (rst) m <= mdlReset();
    else     m <= step(m, sw, start, timer_in);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_2) begin
    check("cyc_led",    {16'h0, led},          {16'h0, m.led});
    check("cyc_hit",    {31'h0, hit},          {31'h0, m.hit});
    check("cyc_miss",   {31'h0, miss},         {31'h0, m.miss});
    check("cyc_active", {31'h0, game_active},  {31'h0, m.active});
  end

  // ---------------- directed sequence ----------------
  task automatic waitShow();
    int n = 0;
    while (!(m.phase == 2'd2) && n < 20) begin
      @(negedge clk_2);
      n++;
    end
    check("wait_show_bound", {31'h0, (n >= 20)}, 32'h0);
  endtask

  logic [15:0] oldLed;
  int          oldIdx;
  int          cnt;

  initial begin
    // Pin the model's arithmetic with hand-computed values.
    check("pin_lfsr1", {16'h0, nextLfsr(16'hACE1)}, 32'hE270);
    check("pin_lfsr4", {16'h0, nextLfsr(nextLfsr(nextLfsr(nextLfsr(16'hACE1))))}, 32'h1C4E);
    check("pin_lfsr0", {16'h0, nextLfsr(16'h0000)}, 32'hACE1);
    check("pin_pick_rep",  choose(16'h0005, 5), 32'd6);
    check("pin_pick_wrap", choose(16'h000F, 15), 32'd0);
    check("pin_pick_new",  choose(16'h1234, 0), 32'd4);

    // Reset with all switches on.
    repeat (3) @(negedge clk_2);
    check("rst_led",    {16'h0, led}, 32'h0);
    check("rst_hit",    {31'h0, hit}, 32'h0);
    check("rst_miss",   {31'h0, miss}, 32'h0);
    check("rst_active", {31'h0, game_active}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk_2);
    check("idle10_active", {31'h0, game_active}, 32'h0);
    check("idle10_led",    {16'h0, led}, 32'h0);

    // Start: active next cycle, first target the cycle after (LFSR after 11 steps = AC58 -> idx 8).
    start = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    check("start_active", {31'h0, game_active}, 32'h1);
    check("start_led0",   {16'h0, led}, 32'h0);
    @(negedge clk_2);
    check("first_onehot", {31'h0, $onehot(led)}, 32'h1);
    check("first_target", {16'h0, led}, 32'h0100);

    // Correct toggle: hit exactly 3 cycles later, one cycle wide.
    oldIdx = int'(m.idx);
    oldLed = 16'h0001 << oldIdx;
    sw = sw ^ oldLed;
    @(negedge clk_2);
    @(negedge clk_2);
    check("hit_early", {31'h0, hit}, 32'h0);
    @(negedge clk_2);
    check("hit_3cyc",  {31'h0, hit}, 32'h1);
    check("hit_nomiss", {31'h0, miss}, 32'h0);
    @(negedge clk_2);
    check("hit_width", {31'h0, hit}, 32'h0);
    check("hit_next_onehot", {31'h0, $onehot(led)}, 32'h1);
    check("hit_next_differs", {31'h0, (led == oldLed)}, 32'h0);

    // Wrong single bit.
    sw = sw ^ (16'h0001 << ((int'(m.idx) + 1) % 16));
    repeat (3) @(negedge clk_2);
    check("wrong_miss", {31'h0, miss}, 32'h1);
    check("wrong_hit",  {31'h0, hit}, 32'h0);
    waitShow();

    // Target plus another bit together.
    sw = sw ^ (16'h0001 << m.idx) ^ (16'h0001 << ((int'(m.idx) + 5) % 16));
    repeat (3) @(negedge clk_2);
    check("multi_miss", {31'h0, miss}, 32'h1);
    check("multi_hit",  {31'h0, hit}, 32'h0);
    waitShow();

    // Twenty timeouts in a row, each after exactly 8 SHOW cycles.
    for (int t = 0; t < 20; t++) begin
      oldLed = led;
      cnt = 0;
      do begin
        @(negedge clk_2);
        cnt++;
      end while (!miss && cnt <= 20);
      check("timeout_len", cnt, 32'd8);
      waitShow();
      check("timeout_onehot", {31'h0, $onehot(led)}, 32'h1);
      check("timeout_differs", {31'h0, (led == oldLed)}, 32'h0);
    end

    // Timer end in the same cycle a correct toggle is evaluated.
    sw = sw ^ (16'h0001 << m.idx);
    @(negedge clk_2);
    @(negedge clk_2);
    timer_in = 6'd31;
    @(negedge clk_2);
    timer_in = 6'd0;
    check("tend_hit",    {31'h0, hit}, 32'h0);
    check("tend_led",    {16'h0, led}, 32'h0);
    check("tend_active", {31'h0, game_active}, 32'h0);

    // Asynchronous reset in the middle of SHOW.
    start = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    waitShow();
    @(negedge clk_2);
    check("prerst_active", {31'h0, game_active}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_led",    {16'h0, led}, 32'h0);
    check("arst_active", {31'h0, game_active}, 32'h0);
    check("arst_hit",    {31'h0, hit}, 32'h0);
    check("arst_miss",   {31'h0, miss}, 32'h0);
    @(negedge clk_2);
    rst = 1'b0;
    repeat (3) @(negedge clk_2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule
